// File: rtl/alu_pkg.sv
// Operation and state encodings shared between the ALU control decoder and
// the iterative ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_SRA = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } alu_state_e;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == ALU_SRA) || (op == ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops: logic, add/sub with signed overflow, set-less-than.
// Shift opcodes pass operand a through; the sequencer handles real shifts.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       aluop,
  input  logic             cmp_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  logic [WIDTH-1:0] sum, diff;
  logic             lt;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt   = cmp_unsigned ? (a < b) : ($signed(a) < $signed(b));

  always_comb begin
    result   = a;
    overflow = 1'b0;
    case (alu_op_e'(aluop))
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_ADD: begin
        result   = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
      default: result = a;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle logic/arith/compare, bit-serial shifts
// (one position per cycle) sequenced by a two-state FSM.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       aluop,
  input  logic             cmp_unsigned,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int SHU = $clog2(WIDTH);
  // Only the low log2(WIDTH) shift-amount bits are meaningful.
  localparam logic [SHW-1:0] SH_MASK = SHW'((64'd1 << SHU) - 64'd1);

  alu_state_e       state;
  logic [SHW-1:0]   cnt;
  logic             sra_q;
  logic [SHW-1:0]   shamt_eff;
  logic [WIDTH-1:0] comb_result, shifted;
  logic             comb_ovf;
  logic             accept;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .aluop        (aluop),
    .cmp_unsigned (cmp_unsigned),
    .a            (a),
    .b            (b),
    .result       (comb_result),
    .overflow     (comb_ovf)
  );

  assign shamt_eff = shamt & SH_MASK;
  assign accept    = start && (state == S_IDLE);

  always_comb begin
    shifted = sra_q ? {result[WIDTH-1], result[WIDTH-1:1]}
                    : {result[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      sra_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_shift_op(aluop) && (shamt_eff != '0)) begin
              result   <= a;
              zero     <= (a == '0);
              overflow <= 1'b0;
              cnt      <= shamt_eff;
              sra_q    <= (aluop == ALU_SRA);
              busy     <= 1'b1;
              state    <= S_SHIFT;
            end else begin
              // Zero-distance shifts fall through as a pass of operand a.
              result   <= comb_result;
              zero     <= (comb_result == '0);
              overflow <= comb_ovf;
              done     <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          result <= shifted;
          zero   <= (shifted == '0);
          cnt    <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: table of single-cycle ops plus hand-written
// shift, back-to-back and reset-abort sequences.
module tb_alu_iter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, cmp_unsigned;
  logic [2:0]  aluop;
  logic [31:0] a, b, result;
  logic [4:0]  shamt;
  logic        zero, overflow, busy, done;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .aluop(aluop),
    .cmp_unsigned(cmp_unsigned), .a(a), .b(b), .shamt(shamt),
    .result(result), .zero(zero), .overflow(overflow), .busy(busy), .done(done)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic        cu;
    logic [31:0] a, b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a shift and follow it to done, counting busy cycles.
  task automatic run_shift(input string nm, input logic [2:0] op, input logic [31:0] av,
                           input logic [4:0] sh, input logic [31:0] exp,
                           input int exp_busy, input logic pulse_start);
    int nbusy;
    logic got_done;
    start = 1'b1; aluop = op; a = av; b = 32'h0; shamt = sh; cmp_unsigned = 1'b0;
    step();
    start = 1'b0;
    nbusy = 0;
    got_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) nbusy++;
      if (pulse_start && i == 1) begin
        start = 1'b1; aluop = ALU_ADD; a = 32'h1; b = 32'h1;
      end
      if (pulse_start && i == 2) start = 1'b0;
      step();
    end
    chk({nm, " done seen"}, 32'(got_done), 32'd1);
    chk({nm, " busy cycles"}, nbusy, exp_busy);
    chk({nm, " result"}, result, exp);
    chk({nm, " zero"}, 32'(zero), 32'(exp == 32'h0));
    chk({nm, " busy at done"}, 32'(busy), 32'd0);
    chk({nm, " overflow"}, 32'(overflow), 32'd0);
    step();
    chk({nm, " done single pulse"}, 32'(done), 32'd0);
    chk({nm, " result held"}, result, exp);
  endtask

  initial begin
    int ndone;
    vecs[0]  = '{"add ovf",       ALU_ADD, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    vecs[1]  = '{"sub eq",        ALU_SUB, 1'b0, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
    vecs[2]  = '{"slt signed",    ALU_SLT, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    vecs[3]  = '{"slt unsigned",  ALU_SLT, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[4]  = '{"and",           ALU_AND, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[5]  = '{"or",            ALU_OR,  1'b0, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0};
    vecs[6]  = '{"xor",           ALU_XOR, 1'b0, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0};
    vecs[7]  = '{"sub ovf",       ALU_SUB, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    vecs[8]  = '{"add wrap",      ALU_ADD, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[9]  = '{"slt min/max s", ALU_SLT, 1'b0, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0};
    vecs[10] = '{"slt min/max u", ALU_SLT, 1'b1, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b0};
    vecs[11] = '{"sub neg",       ALU_SUB, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{"add neg ovf",   ALU_ADD, 1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    vecs[13] = '{"slt eq",        ALU_SLT, 1'b0, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0};

    reset = 1'b1; start = 1'b0; aluop = 3'b0; cmp_unsigned = 1'b0;
    a = '0; b = '0; shamt = '0;
    step(); step();
    chk("reset result", result, 32'h0);
    chk("reset zero", 32'(zero), 32'd1);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      start = 1'b1; aluop = vecs[i].op; cmp_unsigned = vecs[i].cu;
      a = vecs[i].a; b = vecs[i].b; shamt = 5'd0;
      step();
      start = 1'b0;
      chk({vecs[i].name, " done"}, 32'(done), 32'd1);
      chk({vecs[i].name, " result"}, result, vecs[i].res);
      chk({vecs[i].name, " overflow"}, 32'(overflow), 32'(vecs[i].ovf));
      chk({vecs[i].name, " zero"}, 32'(zero), 32'(vecs[i].res == 32'h0));
      chk({vecs[i].name, " busy"}, 32'(busy), 32'd0);
      step();
      chk({vecs[i].name, " done drop"}, 32'(done), 32'd0);
    end

    run_shift("sra4", ALU_SRA, 32'h80000010, 5'd4, 32'hF8000001, 4, 1'b1);
    run_shift("sll31", ALU_SLL, 32'h00000001, 5'd31, 32'h80000000, 31, 1'b0);
    run_shift("sra31 neg", ALU_SRA, 32'h80000000, 5'd31, 32'hFFFFFFFF, 31, 1'b0);
    run_shift("sra31 pos", ALU_SRA, 32'h7FFFFFFF, 5'd31, 32'h00000000, 31, 1'b0);
    run_shift("sll1", ALU_SLL, 32'hC0000001, 5'd1, 32'h80000002, 1, 1'b0);

    // Zero-distance shift then back-to-back AND issued in the done cycle.
    start = 1'b1; aluop = ALU_SLL; a = 32'h1; b = 32'h0; shamt = 5'd0;
    step();
    chk("sll0 done", 32'(done), 32'd1);
    chk("sll0 busy", 32'(busy), 32'd0);
    chk("sll0 result", result, 32'h1);
    aluop = ALU_AND; a = 32'hF0F0F0F0; b = 32'hFF00FF00;
    step();
    start = 1'b0;
    chk("b2b done", 32'(done), 32'd1);
    chk("b2b busy", 32'(busy), 32'd0);
    chk("b2b result", result, 32'hF000F000);
    step();
    chk("b2b done drop", 32'(done), 32'd0);

    // Reset mid-shift aborts with no done afterwards.
    start = 1'b1; aluop = ALU_SLL; a = 32'h1; shamt = 5'd20;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort busy before reset", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort result", result, 32'h0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort zero", 32'(zero), 32'd1);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done || busy) ndone++;
      step();
    end
    chk("abort no late done", ndone, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
